// File: rtl/rr8_grant_sequencer.sv
// rr8_grant_sequencer
//
// Round-robin arbiter for eight requesters. Its outputs drive a 3-to-8
// enabled decoder directly. The winner appears as a binary index (x2_x0)
// qualified by a valid/enable (e). All outputs are registered. Every grant
// is followed by at least one idle cycle, so the decoded one-hot grant is
// always break-before-make.
//
// Optional feature, selected by the macro ARB_HOLD_TIMEOUT_EN:
//   defined   - an 8-bit hold counter is built. A grant that has been held
//               for HOLD_MAX cycles is force-released, and tmo pulses for
//               one cycle.
//   undefined - no counter is built and tmo is tied low.
//
// Parameters:
//   HOLD_MAX   maximum grant length in cycles (1..255); used only with the
//              timeout feature.
// Ports:
//   clock      system clock, rising edge
//   reset_     asynchronous active-low reset
//   req7_req0  request lines, bit i = requester i
//   rel        release strobe from the current grant holder
//   x2_x0      index of the granted requester (held while e = 0)
//   e          grant valid / decoder enable
//   tmo        one-cycle pulse following a forced release

module rr8_grant_sequencer #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic [7:0] req7_req0,
    input  logic       rel,
    output logic [2:0] x2_x0,
    output logic       e,
    output logic       tmo
);

    // Reject an out-of-range hold limit when the design is elaborated.
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_illegal
        $error("rr8_grant_sequencer: HOLD_MAX must be within 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] x_q, x_d;
    logic       e_q, e_d;
    logic       tmo_q, tmo_d;
    logic       timeout;
    logic [2:0] winner;

`ifdef ARB_HOLD_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
`endif

    // Rotating-priority search. It starts one index past the last winner,
    // so the previous holder is considered last and a sole requester still
    // wins. The 3-bit add wraps from 7 back to 0.
    always_comb begin
        logic [2:0] idx;
        logic       found;
        idx    = '0;
        found  = 1'b0;
        winner = ptr_q;
        for (int i = 1; i <= 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && req7_req0[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

`ifdef ARB_HOLD_TIMEOUT_EN
    // cnt_q holds the number of cycles e has been high so far.
    assign timeout = (state_q == GRANT) && (cnt_q >= 8'(HOLD_MAX));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        x_d     = x_q;
        e_d     = e_q;
        tmo_d   = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // rel has no meaning here; only pending requests matter.
                if (|req7_req0) begin
                    state_d = GRANT;
                    x_d     = winner;
                    ptr_d   = winner;
                    e_d     = 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
                    cnt_d   = 8'd1;
`endif
                end
            end
            GRANT: begin
                // Any release cause, or several causes together, ends the
                // grant once. x2_x0 keeps its value through the idle gap.
                if (rel || !req7_req0[x_q] || timeout) begin
                    state_d = IDLE;
                    e_d     = 1'b0;
                    tmo_d   = timeout;
`ifdef ARB_HOLD_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                e_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            ptr_q   <= 3'd7;
            x_q     <= 3'd0;
            e_q     <= 1'b0;
            tmo_q   <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            x_q     <= x_d;
            e_q     <= e_d;
            tmo_q   <= tmo_d;
`ifdef ARB_HOLD_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign x2_x0 = x_q;
    assign e     = e_q;
    assign tmo   = tmo_q;

endmodule

// File: tb/tb_rr8_grant_sequencer.sv
module tb_rr8_grant_sequencer;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int unsigned HM = 4;
`else
    localparam int unsigned HM = 15;
`endif

    logic       clock;
    logic       reset_;
    logic [7:0] req7_req0;
    logic       rel;
    logic [2:0] x2_x0;
    logic       e;
    logic       tmo;

    int checks = 0;
    int errors = 0;

    rr8_grant_sequencer #(.HOLD_MAX(HM)) dut (
        .clock    (clock),
        .reset_   (reset_),
        .req7_req0(req7_req0),
        .rel      (rel),
        .x2_x0    (x2_x0),
        .e        (e),
        .tmo      (tmo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-12s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic exp_e, input logic [2:0] exp_x,
                           input logic exp_tmo);
        chk({tag, ".e"}, 32'(e), 32'(exp_e));
        chk({tag, ".x"}, 32'(x2_x0), 32'(exp_x));
        chk({tag, ".tmo"}, 32'(tmo), 32'(exp_tmo));
    endtask

    initial begin
        reset_    = 1'b0;
        req7_req0 = 8'h00;
        rel       = 1'b0;
        #3;
        chk_out("reset", 1'b0, 3'd0, 1'b0);
        tick();
        tick();
        reset_ = 1'b1;

        // Sole requester 0: granted one edge later and held.
        req7_req0 = 8'h01;
        tick();
        chk_out("hold0.c1", 1'b1, 3'd0, 1'b0);
        tick();
        chk_out("hold0.c2", 1'b1, 3'd0, 1'b0);
        tick();
        chk_out("hold0.c3", 1'b1, 3'd0, 1'b0);
        req7_req0 = 8'h00;
        tick();
        chk_out("hold0.wd", 1'b0, 3'd0, 1'b0);

        // All requesting, rel on each grant: last winner was 0, so 1..7,0,1.
        req7_req0 = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [2:0] exp_idx;
            exp_idx = 3'((k + 1) % 8);
            tick();
            chk_out($sformatf("all.g%0d", k), 1'b1, exp_idx, 1'b0);
            rel = 1'b1;
            tick();
            rel = 1'b0;
            chk_out($sformatf("all.gap%0d", k), 1'b0, exp_idx, 1'b0);
        end

        // Requesters 0 and 7, last winner 1: 7,0,7,0.
        req7_req0 = 8'h81;
        for (int k = 0; k < 4; k++) begin
            logic [2:0] exp_idx;
            exp_idx = (k % 2 == 0) ? 3'd7 : 3'd0;
            tick();
            chk_out($sformatf("alt.g%0d", k), 1'b1, exp_idx, 1'b0);
            rel = 1'b1;
            tick();
            rel = 1'b0;
            chk_out($sformatf("alt.gap%0d", k), 1'b0, exp_idx, 1'b0);
        end

        // Grant 3, withdraw it; 5 is granted one cycle later.
        req7_req0 = 8'h28;
        tick();
        chk_out("wd.g3", 1'b1, 3'd3, 1'b0);
        req7_req0 = 8'h20;
        tick();
        chk_out("wd.off", 1'b0, 3'd3, 1'b0);
        tick();
        chk_out("wd.g5", 1'b1, 3'd5, 1'b0);
        req7_req0 = 8'h00;
        tick();
        chk_out("wd.off5", 1'b0, 3'd5, 1'b0);
        // rel asserted in IDLE together with a request: rel is ignored.
        rel       = 1'b1;
        req7_req0 = 8'h04;
        tick();
        rel = 1'b0;
        chk_out("idlerel.g2", 1'b1, 3'd2, 1'b0);
        tick();
        chk_out("idlerel.h2", 1'b1, 3'd2, 1'b0);
        req7_req0 = 8'h00;
        tick();
        chk_out("idlerel.off", 1'b0, 3'd2, 1'b0);

        // Only requester 5 held, no rel.
        req7_req0 = 8'h20;
`ifdef ARB_HOLD_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out($sformatf("tmo.h%0d", k), 1'b1, 3'd5, 1'b0);
        end
        tick();
        chk_out("tmo.pulse", 1'b0, 3'd5, 1'b1);
        tick();
        chk_out("tmo.regrant", 1'b1, 3'd5, 1'b0);
`else
        for (int k = 0; k < 22; k++) begin
            tick();
            chk_out($sformatf("notmo.h%0d", k), 1'b1, 3'd5, 1'b0);
        end
`endif
        req7_req0 = 8'h00;
        tick();
        chk_out("tmo.wd", 1'b0, 3'd5, 1'b0);

        // Reset between edges while a grant is held.
        req7_req0 = 8'h01;
        tick();
        chk_out("rst.g0", 1'b1, 3'd0, 1'b0);
        #2;
        reset_ = 1'b0;
        #1;
        chk_out("rst.async", 1'b0, 3'd0, 1'b0);
        req7_req0 = 8'h04;
        tick();
        chk_out("rst.held", 1'b0, 3'd0, 1'b0);
        reset_ = 1'b1;
        tick();
        chk_out("rst.g2", 1'b1, 3'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
